// File: rtl/tpx3_sync_sequencer.sv
// -----------------------------------------------------------------------------
// tpx3_sync_sequencer
//   Generates (host) or regenerates (client) the Timepix3 Reset / T0_Sync
//   sequence so that every board in a chain releases reset and fires T0 on a
//   deterministic clock cycle.
//
// Ports
//   CLK, RST_N          chip-domain clock, asynchronous active-low reset
//   MODE_HOST           1 = host (local sequence), 0 = client; sampled in IDLE
//   START               host: one-cycle request to run the sequence
//   RESET_LEN[7:0]      host: reset pulse length in cycles (0 acts as 1)
//   T0_DELAY[15:0]      host: cycles from reset release to T0 rise
//   EXT_RESET_IN        client: asynchronous external reset level
//   EXT_T0_IN           client: asynchronous external T0 level
//   TPX_RESET           chip reset driver, active high
//   TPX_T0_SYNC         chip T0_Sync driver
//   EXT_RESET_OUT       host copy of TPX_RESET for client boards
//   EXT_T0_OUT          host copy of TPX_T0_SYNC for client boards
//   BUSY                high whenever the FSM is not in IDLE
//   DONE                sticky, sequence completed
//   ERROR               sticky, client T0 timeout
// -----------------------------------------------------------------------------
module tpx3_sync_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int T0_WIDTH    = 4,
   parameter int TIMEOUT     = 65535
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        MODE_HOST,
   input  logic        START,
   input  logic [7:0]  RESET_LEN,
   input  logic [15:0] T0_DELAY,
   input  logic        EXT_RESET_IN,
   input  logic        EXT_T0_IN,
   output logic        TPX_RESET,
   output logic        TPX_T0_SYNC,
   output logic        EXT_RESET_OUT,
   output logic        EXT_T0_OUT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR
);

   // One shared counter covers reset length, T0 delay, T0 width and timeout.
   localparam int CW_T = ($clog2(TIMEOUT + 1) > $clog2(T0_WIDTH + 1)) ?
                         $clog2(TIMEOUT + 1) : $clog2(T0_WIDTH + 1);
   localparam int CW   = (CW_T > 16) ? CW_T : 16;

   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] T0_LAST = CW'(T0_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, H_RST, H_WAIT, C_RST, C_WAIT, T0_PULSE
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [7:0]       rl_q;
   logic [15:0]      td_q;
   logic             host_run, host_nxt;
   logic             done_nxt, error_nxt;
   logic             latch;

   // ---------------------------------------------------------------------------
   // Client input synchronizers and edge detectors
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rst_sync, t0_sync;
   logic                   rst_prev, t0_prev;
   logic                   rst_lvl, t0_lvl, rst_rise, t0_rise;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync <= '0;
         t0_sync  <= '0;
         rst_prev <= 1'b0;
         t0_prev  <= 1'b0;
      end else begin
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], EXT_RESET_IN};
         t0_sync  <= {t0_sync[SYNC_STAGES-2:0], EXT_T0_IN};
         rst_prev <= rst_lvl;
         t0_prev  <= t0_lvl;
      end
   end

   assign rst_lvl  = rst_sync[SYNC_STAGES-1];
   assign t0_lvl   = t0_sync[SYNC_STAGES-1];
   // prev tracks the level continuously, so a T0 level that is already high
   // when C_WAIT is entered never produces an edge.
   assign rst_rise = rst_lvl & ~rst_prev;
   assign t0_rise  = t0_lvl & ~t0_prev;

   // ---------------------------------------------------------------------------
   // FSM next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      host_nxt  = host_run;
      done_nxt  = DONE;
      error_nxt = ERROR;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (MODE_HOST) begin
               if (START) begin
                  state_nxt = H_RST;
                  host_nxt  = 1'b1;
                  done_nxt  = 1'b0;
                  error_nxt = 1'b0;
                  latch     = 1'b1;
               end
            end else if (rst_rise) begin
               state_nxt = C_RST;
               host_nxt  = 1'b0;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
            end
         end
         H_RST: begin
            if (cnt == CW'(rl_q - 8'd1)) begin
               cnt_nxt   = '0;
               // zero delay skips H_WAIT so T0 follows reset release directly
               state_nxt = (td_q == 16'd0) ? T0_PULSE : H_WAIT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         H_WAIT: begin
            if (cnt == CW'(td_q - 16'd1)) begin
               cnt_nxt   = '0;
               state_nxt = T0_PULSE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         C_RST: begin
            if (!rst_lvl) begin
               cnt_nxt   = '0;
               state_nxt = C_WAIT;
            end
         end
         C_WAIT: begin
            if (rst_rise) begin
               cnt_nxt   = '0;
               state_nxt = C_RST;
            end else if (t0_rise) begin
               cnt_nxt   = '0;
               state_nxt = T0_PULSE;
            end else if (cnt == TO_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               error_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         T0_PULSE: begin
            if (cnt == T0_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, latched parameters and registered outputs. Outputs are decoded
   // from the next state so each pulse starts on the transition edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         cnt           <= '0;
         rl_q          <= 8'd1;
         td_q          <= '0;
         host_run      <= 1'b0;
         TPX_RESET     <= 1'b0;
         TPX_T0_SYNC   <= 1'b0;
         EXT_RESET_OUT <= 1'b0;
         EXT_T0_OUT    <= 1'b0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         ERROR         <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         host_run <= host_nxt;
         DONE     <= done_nxt;
         ERROR    <= error_nxt;
         if (latch) begin
            rl_q <= (RESET_LEN == 8'd0) ? 8'd1 : RESET_LEN;
            td_q <= T0_DELAY;
         end
         TPX_RESET     <= (state_nxt == H_RST) || (state_nxt == C_RST);
         TPX_T0_SYNC   <= (state_nxt == T0_PULSE);
         EXT_RESET_OUT <= (state_nxt == H_RST);
         EXT_T0_OUT    <= (state_nxt == T0_PULSE) && host_nxt;
         BUSY          <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_tpx3_sync_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpx3_sync_sequencer
//   Directed bench. u_dut uses default parameters; u_dut_to shares all inputs
//   but has TIMEOUT=100 for the client timeout case. Inputs change on the
//   falling edge; outputs are sampled on the falling edge. Cycle c means the
//   falling edge c cycles after the one where the stimulus was applied.
// -----------------------------------------------------------------------------
module tb_tpx3_sync_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode_host, start, ext_reset_in, ext_t0_in;
   logic [7:0]  reset_len;
   logic [15:0] t0_delay;

   logic tpx_reset, tpx_t0, ext_reset_out, ext_t0_out, busy, done, error;
   logic tpx_reset_b, tpx_t0_b, ext_reset_out_b, ext_t0_out_b, busy_b, done_b, error_b;

   int n_chk  = 0;
   int n_pass = 0;

   int r_first, r_cnt, t_first, t_cnt, er_cnt, et_cnt, b_cnt;

   always #5 clk = ~clk;

   tpx3_sync_sequencer u_dut (
      .CLK(clk), .RST_N(rst_n), .MODE_HOST(mode_host), .START(start),
      .RESET_LEN(reset_len), .T0_DELAY(t0_delay),
      .EXT_RESET_IN(ext_reset_in), .EXT_T0_IN(ext_t0_in),
      .TPX_RESET(tpx_reset), .TPX_T0_SYNC(tpx_t0),
      .EXT_RESET_OUT(ext_reset_out), .EXT_T0_OUT(ext_t0_out),
      .BUSY(busy), .DONE(done), .ERROR(error)
   );

   tpx3_sync_sequencer #(.TIMEOUT(100)) u_dut_to (
      .CLK(clk), .RST_N(rst_n), .MODE_HOST(mode_host), .START(start),
      .RESET_LEN(reset_len), .T0_DELAY(t0_delay),
      .EXT_RESET_IN(ext_reset_in), .EXT_T0_IN(ext_t0_in),
      .TPX_RESET(tpx_reset_b), .TPX_T0_SYNC(tpx_t0_b),
      .EXT_RESET_OUT(ext_reset_out_b), .EXT_T0_OUT(ext_t0_out_b),
      .BUSY(busy_b), .DONE(done_b), .ERROR(error_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
   endtask

   task automatic clr_stats();
      r_first = -1; t_first = -1;
      r_cnt = 0; t_cnt = 0; er_cnt = 0; et_cnt = 0; b_cnt = 0;
   endtask

   task automatic samp(input int c);
      if (tpx_reset) begin if (r_first < 0) r_first = c; r_cnt++; end
      if (tpx_t0)    begin if (t_first < 0) t_first = c; t_cnt++; end
      if (ext_reset_out) er_cnt++;
      if (ext_t0_out)    et_cnt++;
      if (busy)          b_cnt++;
   endtask

   initial begin
      rst_n = 1'b0; mode_host = 1'b0; start = 1'b0;
      ext_reset_in = 1'b0; ext_t0_in = 1'b0;
      reset_len = 8'd0; t0_delay = 16'd0;

      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", {tpx_reset, tpx_t0, ext_reset_out, ext_t0_out, busy, done, error}, 0);
      chk("rst_outs_to", {tpx_reset_b, tpx_t0_b, ext_reset_out_b, ext_t0_out_b,
                          busy_b, done_b, error_b}, 0);
      rst_n = 1'b1;

      // ---- host RESET_LEN=10 T0_DELAY=20
      @(negedge clk);
      mode_host = 1'b1; reset_len = 8'd10; t0_delay = 16'd20; start = 1'b1;
      clr_stats();
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk); samp(c);
         if (c == 1) start = 1'b0;
      end
      chk("h1_rst_first", r_first, 1);
      chk("h1_rst_width", r_cnt, 10);
      chk("h1_t0_first", t_first, 31);
      chk("h1_t0_width", t_cnt, 4);
      chk("h1_ext_rst", er_cnt, 10);
      chk("h1_ext_t0", et_cnt, 4);
      chk("h1_busy_cycles", b_cnt, 34);
      chk("h1_done_busy", {done, busy, error}, 3'b100);

      // ---- host RESET_LEN=0 T0_DELAY=0, START repeated while busy
      reset_len = 8'd0; t0_delay = 16'd0; start = 1'b1;
      clr_stats();
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk); samp(c);
         if (c == 1) begin chk("h2_done_clr", done, 0); start = 1'b0; end
         if (c == 2) start = 1'b1;
         if (c == 3) start = 1'b0;
      end
      chk("h2_rst_first", r_first, 1);
      chk("h2_rst_width", r_cnt, 1);
      chk("h2_t0_first", t_first, 2);
      chk("h2_t0_width", t_cnt, 4);
      chk("h2_done", {done, busy}, 2'b10);

      // ---- START in client mode is ignored
      mode_host = 1'b0; start = 1'b1;
      clr_stats();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); samp(c);
         if (c == 1) start = 1'b0;
      end
      chk("cli_start_ign", b_cnt + r_cnt, 0);

      // ---- client: reset high 50 cycles, T0 edge 100 cycles after release
      ext_reset_in = 1'b1;
      clr_stats();
      for (int c = 1; c <= 170; c++) begin
         @(negedge clk); samp(c);
         if (c == 3)   chk("c1_done_clr", done, 0);
         if (c == 50)  ext_reset_in = 1'b0;
         if (c == 150) ext_t0_in = 1'b1;
         if (c == 160) ext_t0_in = 1'b0;
      end
      chk("c1_rst_first", r_first, 3);
      chk("c1_rst_width", r_cnt, 50);
      chk("c1_t0_first", t_first, 153);
      chk("c1_t0_width", t_cnt, 4);
      chk("c1_ext_outs", er_cnt + et_cnt, 0);
      chk("c1_done", {done, busy, error}, 3'b100);

      // ---- client timeout (TIMEOUT=100 instance); T0 rises during C_RST
      //      and is still high at release, so C_WAIT detects no T0 rise
      ext_reset_in = 1'b1;
      clr_stats();
      for (int c = 1; c <= 170; c++) begin
         @(negedge clk); samp(c);
         if (c == 10) ext_t0_in = 1'b1;
         if (c == 30) ext_reset_in = 1'b0;
         if (c == 132) chk("to_err_early", {error_b, busy_b}, 2'b01);
         if (c == 133) begin
            chk("to_err_set", {error_b, busy_b, done_b}, 3'b100);
            chk("to_main_waiting", busy, 1);
         end
         if (c == 140) ext_t0_in = 1'b0;
         if (c == 150) ext_reset_in = 1'b1;
         if (c == 153) begin
            chk("to_err_clr", {error_b, tpx_reset_b}, 2'b01);
            chk("to_main_restart", tpx_reset, 1);
         end
         if (c == 160) ext_reset_in = 1'b0;
      end
      chk("to_rst_first", r_first, 3);
      chk("to_no_t0", t_cnt, 0);

      // clear the waiting client FSMs
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_idle", {busy, busy_b}, 0);

      // ---- host, RST_N asserted during H_RST: reset drops without a clock
      mode_host = 1'b1; reset_len = 8'd5; t0_delay = 16'd50; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_hrst", {tpx_reset, ext_reset_out, busy}, 0);
      @(negedge clk); rst_n = 1'b1;

      // ---- host, RST_N asserted during H_WAIT
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 20) chk("hw_in_wait", {busy, tpx_reset, tpx_t0}, 3'b100);
      end
      #2 rst_n = 1'b0;
      #1 chk("async_hwait", {tpx_reset, tpx_t0, ext_reset_out, ext_t0_out,
                             busy, done, error}, 0);
      @(negedge clk); rst_n = 1'b1;
      clr_stats();
      for (int c = 1; c <= 60; c++) begin @(negedge clk); samp(c); end
      chk("no_resume", b_cnt + r_cnt + t_cnt, 0);

      // ---- host, inputs changed mid-sequence (and MODE_HOST flipped)
      reset_len = 8'd3; t0_delay = 16'd5; start = 1'b1;
      clr_stats();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); samp(c);
         if (c == 1) begin start = 1'b0; reset_len = 8'd20; t0_delay = 16'd40; end
         if (c == 2) mode_host = 1'b0;
      end
      chk("lat_rst_first", r_first, 1);
      chk("lat_rst_width", r_cnt, 3);
      chk("lat_t0_first", t_first, 9);
      chk("lat_t0_width", t_cnt, 4);
      chk("lat_ext", er_cnt + et_cnt, 7);
      chk("lat_done", {done, busy}, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tpx3_sync_sequencer.md
Name: tpx3_sync_sequencer

Overview:
Sequences the Timepix3 chip Reset and T0_Sync pulses on a readout board. In host mode it generates the sequence locally and forwards both pulses to the external sync connectors for client boards. In client mode it regenerates the same sequence from the external connector inputs. It sits between the control register block and the TPX3 Reset/T0_Sync LVDS output drivers, and makes multi-board T0 alignment deterministic.

Parameters:
SYNC_STAGES, 2, synchronizer flops on each external input (minimum 2)
T0_WIDTH, 4, T0_Sync pulse width in CLK cycles (minimum 1)
TIMEOUT, 65535, client: maximum cycles allowed from reset release to T0 edge before ERROR

Ports:
CLK  in  1  chip-domain clock (40 MHz)
RST_N  in  1  asynchronous active-low reset
MODE_HOST  in  1  1=host, 0=client; sampled only in IDLE
START  in  1  host: single-cycle request to run the sequence
RESET_LEN  in  8  host: TPX reset pulse length in cycles; 0 treated as 1
T0_DELAY  in  16  host: cycles from reset release to T0 rise
EXT_RESET_IN  in  1  client: external reset level (asynchronous)
EXT_T0_IN  in  1  client: external T0 level (asynchronous)
TPX_RESET  out  1  to chip reset driver, active high
TPX_T0_SYNC  out  1  to chip T0_Sync driver
EXT_RESET_OUT  out  1  host: copy of TPX_RESET; 0 in client mode
EXT_T0_OUT  out  1  host: copy of TPX_T0_SYNC; 0 in client mode
BUSY  out  1  high in any state other than IDLE
DONE  out  1  sticky; set when a sequence completes, cleared on the next sequence start
ERROR  out  1  sticky; client T0 timeout, cleared on the next sequence start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronizers cleared. Asserting RST_N mid-sequence drops TPX_RESET and T0 immediately, without waiting for a clock.
- All outputs are registered. EXT_*_OUT equal TPX_* in the same cycle when in host mode.
- FSM states: IDLE, H_RST, H_WAIT, C_RST, C_WAIT, T0_PULSE.
- IDLE, host mode: START=1 moves to H_RST on the next cycle.
  - Latch RESET_LEN and T0_DELAY on this transition. Later changes do not affect a running sequence.
  - Clear DONE and ERROR.
- H_RST: TPX_RESET=1 for exactly max(RESET_LEN,1) cycles, then go to H_WAIT.
- H_WAIT: TPX_RESET=0 for exactly T0_DELAY cycles, then go to T0_PULSE. With T0_DELAY=0, T0 rises in the cycle immediately after TPX_RESET falls.
- T0_PULSE: TPX_T0_SYNC=1 for exactly T0_WIDTH cycles, then go to IDLE and set DONE.
- START is ignored while BUSY. START in client mode is ignored.
- Client path: EXT inputs pass through SYNC_STAGES flops, then a registered edge detector.
- IDLE, client mode: a synchronized rising edge of EXT_RESET_IN moves to C_RST and clears DONE and ERROR. TPX_RESET rises SYNC_STAGES+1 cycles after the input edge.
- C_RST: TPX_RESET follows the synchronized EXT_RESET_IN level. On its falling edge, TPX_RESET=0 and the FSM goes to C_WAIT with the timeout counter at 0.
- C_WAIT: a rising edge of synchronized EXT_T0_IN moves to T0_PULSE, which behaves as in host mode.
  - If the counter reaches TIMEOUT without an edge, set ERROR and go to IDLE. DONE is not set.
  - A new EXT_RESET_IN rising edge in C_WAIT restarts C_RST.
- A T0 edge while in C_RST is ignored. An EXT_T0_IN level that is already high when entering C_WAIT does not count as an edge.
- A MODE_HOST change while BUSY has no effect until IDLE.
- Total host sequence, counted from the cycle after START, takes RESET_LEN'+T0_DELAY+T0_WIDTH cycles, where RESET_LEN'=max(RESET_LEN,1).

Test Plan:
- Host, RESET_LEN=10, T0_DELAY=20, START pulse →
  - TPX_RESET and EXT_RESET_OUT high for 10 cycles.
  - Low for 20 cycles.
  - TPX_T0_SYNC and EXT_T0_OUT high for 4 cycles.
  - DONE=1, BUSY=0.
- Host, RESET_LEN=0, T0_DELAY=0 → 1-cycle reset, T0 rises the next cycle; START repeated while BUSY causes no restart.
- Client, EXT_RESET_IN high 50 cycles, then EXT_T0_IN rise 100 cycles later →
  - TPX_RESET high 50 cycles, delayed 3 cycles.
  - T0 pulse 4 cycles wide starting 3 cycles after the edge.
  - EXT_*_OUT stay 0; DONE=1.
- Client, TIMEOUT=100, no T0 edge after reset release → ERROR=1 at cycle 100 after release, FSM in IDLE, DONE=0; the next reset edge clears ERROR.
- Host, RST_N asserted during H_WAIT → all outputs 0 asynchronously; after release, IDLE and START required for a new sequence.
- Host, RESET_LEN/T0_DELAY changed mid-sequence → timing still matches the values latched at START.
